// File: rtl/axi2mem_arb_pkg.sv
// Shared types and constants for the axi2mem read/write command arbiter.
package axi2mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, RD_OWN, WR_OWN} arb_state_e;

  localparam logic SRC_RD = 1'b0;
  localparam logic SRC_WR = 1'b1;

  function automatic arb_state_e own_state(input logic src);
    return (src == SRC_WR) ? WR_OWN : RD_OWN;
  endfunction

endpackage

// File: rtl/axi2mem_arb_stall_cnt.sv
// Saturating stall counter; flags a timeout on the stall cycle that hits TIMEOUT_CYCLES-1.
module axi2mem_arb_stall_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (stall_i && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = stall_i && (cnt_q == LIMIT);

endmodule

// File: rtl/axi2mem_cmd_arbiter.sv
// Burst-locked arbiter sharing the two TCDM lanes between axi2mem rd and wr issuers.
// Define AXI2MEM_ARB_WR_PRIO_EN for fixed write priority instead of round-robin.
module axi2mem_cmd_arbiter
  import axi2mem_arb_pkg::*;
#(
  parameter int ID_WIDTH       = 6,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rd_pend_i,
  input  logic [1:0]                 rd_req_i,
  input  logic [1:0][ID_WIDTH-1:0]   rd_id_i,
  input  logic [1:0][ADDR_WIDTH-1:0] rd_add_i,
  input  logic [1:0]                 rd_last_i,
  output logic [1:0]                 rd_gnt_o,
  input  logic                       wr_pend_i,
  input  logic [1:0]                 wr_req_i,
  input  logic [1:0][ID_WIDTH-1:0]   wr_id_i,
  input  logic [1:0][ADDR_WIDTH-1:0] wr_add_i,
  input  logic [1:0]                 wr_last_i,
  output logic [1:0]                 wr_gnt_o,
  output logic [1:0]                 trans_req_o,
  output logic [1:0][ID_WIDTH-1:0]   trans_id_o,
  output logic [1:0][ADDR_WIDTH-1:0] trans_add_o,
  output logic [1:0]                 trans_last_o,
  output logic                       trans_src_o,
  input  logic [1:0]                 trans_gnt_i,
  output logic                       timeout_o
);

  typedef struct packed {
    logic [1:0][ID_WIDTH-1:0]   id;
    logic [1:0][ADDR_WIDTH-1:0] add;
    logic [1:0]                 last;
    logic [1:0]                 req;
  } beat_t;

  arb_state_e state_d, state_q;
  beat_t      rd_beat, wr_beat, sel_beat, out_beat;
  logic       sel_vld, sel_src;
  logic       accept, last_acc, owned, stall, to_hit;
`ifndef AXI2MEM_ARB_WR_PRIO_EN
  logic       rr_d, rr_q;
`endif

  assign rd_beat = '{id: rd_id_i, add: rd_add_i, last: rd_last_i, req: rd_req_i};
  assign wr_beat = '{id: wr_id_i, add: wr_add_i, last: wr_last_i, req: wr_req_i};

  // Selection looks only at pend/state/rr so gnt never depends on req.
  always_comb begin
    sel_vld = 1'b0;
    sel_src = SRC_RD;
    case (state_q)
      IDLE: begin
`ifdef AXI2MEM_ARB_WR_PRIO_EN
        if (wr_pend_i)      begin sel_vld = 1'b1; sel_src = SRC_WR; end
        else if (rd_pend_i) begin sel_vld = 1'b1; sel_src = SRC_RD; end
`else
        if (rd_pend_i && (rr_q == SRC_RD || !wr_pend_i)) begin sel_vld = 1'b1; sel_src = SRC_RD; end
        else if (wr_pend_i)                              begin sel_vld = 1'b1; sel_src = SRC_WR; end
`endif
      end
      RD_OWN:  begin sel_vld = 1'b1; sel_src = SRC_RD; end
      WR_OWN:  begin sel_vld = 1'b1; sel_src = SRC_WR; end
      default: ;
    endcase
    if (rst_i) sel_vld = 1'b0;
  end

  assign sel_beat = (sel_src == SRC_WR) ? wr_beat : rd_beat;
  assign out_beat = sel_vld ? sel_beat : '0;

  assign trans_req_o  = out_beat.req;
  assign trans_id_o   = out_beat.id;
  assign trans_add_o  = out_beat.add;
  assign trans_last_o = out_beat.last;
  assign trans_src_o  = sel_vld & sel_src;

  assign rd_gnt_o = (sel_vld && sel_src == SRC_RD) ? trans_gnt_i : 2'b00;
  assign wr_gnt_o = (sel_vld && sel_src == SRC_WR) ? trans_gnt_i : 2'b00;

  // Partial lane handshakes are forwarded but never move the FSM.
  assign accept   = sel_vld && (sel_beat.req == 2'b11) && (trans_gnt_i == 2'b11);
  assign last_acc = accept && (sel_beat.last == 2'b11);
  assign owned    = !rst_i && (state_q != IDLE);
  assign stall    = owned && !accept;

  axi2mem_arb_stall_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_stall_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_i   (stall),
    .clr_i     (!owned || accept),
    .timeout_o (to_hit)
  );

  assign timeout_o = to_hit;

  always_comb begin
    state_d = state_q;
`ifndef AXI2MEM_ARB_WR_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && !last_acc) state_d = own_state(sel_src);
`ifndef AXI2MEM_ARB_WR_PRIO_EN
        if (last_acc)            rr_d = ~rr_q;
`endif
      end
      RD_OWN, WR_OWN: begin
        if (last_acc || to_hit) begin
          state_d = IDLE;
`ifndef AXI2MEM_ARB_WR_PRIO_EN
          rr_d    = (state_q == RD_OWN) ? SRC_WR : SRC_RD;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
`ifndef AXI2MEM_ARB_WR_PRIO_EN
      rr_q    <= SRC_RD;
`endif
    end else begin
      state_q <= state_d;
`ifndef AXI2MEM_ARB_WR_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule
